// File: rtl/zpaq_pkg.sv
// Shared types for the compressor output path: packer FSM states and AXIS keep constants.
package zpaq_pkg;

    typedef enum logic [1:0] {
        S_Idle,
        S_Run,
        S_FlushPart,
        S_Trailer
    } packer_state_t;

    localparam int unsigned KEEP_W = 8;
    localparam logic [KEEP_W-1:0] TKEEP_ALL = '1;

endpackage

// File: rtl/comp_out_packer_if.sv
// Byte-in / AXI4-Stream-out bundle for the packer. The master modport is the packer's view
// (byte consumer, word producer); slave is the surrounding environment.
interface comp_out_packer_if #(
    parameter int unsigned IN_DW  = 8,
    parameter int unsigned OUT_DW = 64
);
    logic [IN_DW-1:0]    ByteIn;
    logic                ByteInValid;
    logic                ByteInReady;
    logic [OUT_DW-1:0]   m_tdata;
    logic [OUT_DW/8-1:0] m_tkeep;
    logic                m_tlast;
    logic                m_tvalid;
    logic                m_tready;

    modport master (
        input  ByteIn, ByteInValid, m_tready,
        output ByteInReady, m_tdata, m_tkeep, m_tlast, m_tvalid
    );

    modport slave (
        output ByteIn, ByteInValid, m_tready,
        input  ByteInReady, m_tdata, m_tkeep, m_tlast, m_tvalid
    );
endinterface

// File: rtl/comp_out_packer.sv
// Packs compressor output bytes little-endian into AXIS words; on flush emits the partial
// word (reduced tkeep) and a tlast trailer carrying the total byte count.
module comp_out_packer
    import zpaq_pkg::*;
#(
    parameter int unsigned IN_DW  = 8,
    parameter int unsigned OUT_DW = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    comp_out_packer_if.master  bus,
    output logic [CNT_W-1:0]   TotalBytes,
    output logic               FlushDone
);

    localparam int unsigned LANES  = OUT_DW / IN_DW;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned KW     = OUT_DW / 8;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    packer_state_t state_q, state_d;

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [OUT_DW-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_DW-1:0] tdata_q, tdata_d;
    logic [KW-1:0]     tkeep_q, tkeep_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic              trl_ld_q, trl_ld_d;

    logic              out_free;
    logic              byte_rdy;
    logic              accept;
    logic              lane_last;
    logic [LANE_W-1:0] lane_adv;
    logic [OUT_DW-1:0] acc_nxt;

    function automatic logic [KW-1:0] part_keep(input logic [LANE_W-1:0] n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < int'(KW); i++) begin
            k[i] = (i < int'(n));
        end
        return k;
    endfunction

    // Output register can take a new word when empty or draining this cycle.
    assign out_free  = ~tvalid_q | bus.m_tready;
    assign lane_last = (lane_q == LANE_LAST);
    assign byte_rdy  = (state_q == S_Run) & (~lane_last | out_free);
    assign accept    = byte_rdy & bus.ByteInValid;
    assign lane_adv  = accept ? (lane_last ? '0 : lane_q + LANE_W'(1)) : lane_q;

    always_comb begin
        acc_nxt = acc_q;
        if (accept) begin
            acc_nxt[IN_DW*int'(lane_q) +: IN_DW] = bus.ByteIn;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_Idle:      if (start) state_d = S_Run;
            S_Run:       if (flush) state_d = (lane_adv != '0) ? S_FlushPart : S_Trailer;
            S_FlushPart: if (out_free) state_d = S_Trailer;
            S_Trailer:   if (trl_ld_q && FlushDone) state_d = S_Idle;
            default:     state_d = S_Idle;
        endcase
    end

    // Datapath next-state; the partial word goes out in the flush cycle when the register is free.
    always_comb begin
        lane_d   = lane_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        trl_ld_d = trl_ld_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q & ~bus.m_tready;
        unique case (state_q)
            S_Idle: begin
                if (start) begin
                    lane_d = '0;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            S_Run: begin
                lane_d = lane_adv;
                acc_d  = acc_nxt;
                if (accept) cnt_d = cnt_q + CNT_W'(1);
                if (accept && lane_last) begin
                    tdata_d  = acc_nxt;
                    tkeep_d  = TKEEP_ALL;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    acc_d    = '0;
                end else if (flush && (lane_adv != '0) && out_free) begin
                    tdata_d  = acc_nxt;
                    tkeep_d  = part_keep(lane_adv);
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    lane_d   = '0;
                    acc_d    = '0;
                end
            end
            S_FlushPart: begin
                if (out_free) begin
                    tvalid_d = 1'b1;
                    if (lane_q != '0) begin
                        tdata_d = acc_q;
                        tkeep_d = part_keep(lane_q);
                        tlast_d = 1'b0;
                        lane_d  = '0;
                        acc_d   = '0;
                    end else begin
                        tdata_d              = '0;
                        tdata_d[CNT_W-1:0]   = cnt_q;
                        tkeep_d              = TKEEP_ALL;
                        tlast_d              = 1'b1;
                        trl_ld_d             = 1'b1;
                    end
                end
            end
            S_Trailer: begin
                if (!trl_ld_q) begin
                    if (out_free) begin
                        tdata_d            = '0;
                        tdata_d[CNT_W-1:0] = cnt_q;
                        tkeep_d            = TKEEP_ALL;
                        tlast_d            = 1'b1;
                        tvalid_d           = 1'b1;
                        trl_ld_d           = 1'b1;
                    end
                end else if (FlushDone) begin
                    trl_ld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            trl_ld_q <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            trl_ld_q <= trl_ld_d;
        end
    end

    // Outputs
    always_comb begin
        bus.ByteInReady = byte_rdy;
        bus.m_tdata     = tdata_q;
        bus.m_tkeep     = tkeep_q;
        bus.m_tlast     = tlast_q;
        bus.m_tvalid    = tvalid_q;
        TotalBytes      = cnt_q;
        FlushDone       = tvalid_q & bus.m_tready & tlast_q;
    end

endmodule

// File: tb/tb_comp_out_packer.sv
// Directed + randomized bench for comp_out_packer; expected words are rebuilt from the
// accepted byte list by chunking it into 8-byte groups plus a byte-count trailer.
module tb_comp_out_packer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] total_bytes;
    logic        flush_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  acc_bytes[$];
    logic [63:0] cap_data[$];
    logic [7:0]  cap_keep[$];
    logic        cap_last[$];
    logic        cap_fd[$];

    comp_out_packer_if #(.IN_DW(8), .OUT_DW(64)) bif ();

    comp_out_packer #(
        .IN_DW (8),
        .OUT_DW(64),
        .CNT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .bus       (bif),
        .TotalBytes(total_bytes),
        .FlushDone (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte and word handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.ByteInValid && bif.ByteInReady) acc_bytes.push_back(bif.ByteIn);
            if (bif.m_tvalid && bif.m_tready) begin
                cap_data.push_back(bif.m_tdata);
                cap_keep.push_back(bif.m_tkeep);
                cap_last.push_back(bif.m_tlast);
                cap_fd.push_back(flush_done);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        acc_bytes.delete();
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
        cap_fd.delete();
    endtask

    task automatic start_stream(input logic check_ready);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (check_ready) chk("ready_after_start", 64'(bif.ByteInReady), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_flush);
        int guard = 0;
        bit got   = 1'b0;
        bif.ByteIn      = b;
        bif.ByteInValid = 1'b1;
        flush           = with_flush;
        while (!got && guard < 100) begin
            @(negedge clk);
            if (bif.ByteInReady) got = 1'b1;
            guard++;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        bif.ByteInValid = 1'b0;
        chk("byte_accept", 64'(got), 64'd1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (flush_done) got = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 64'(got), 64'd1);
    endtask

    // Expected output: ceil(n/8) data words, last one possibly partial, then the trailer.
    task automatic check_stream(input string tag);
        int          n;
        int          nw;
        int          idx;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        n   = acc_bytes.size();
        nw  = (n + 7) / 8;
        idx = 0;
        chk({tag, "_nwords"}, 64'(cap_data.size()), 64'(nw + 1));
        for (int w = 0; w <= nw && w < cap_data.size(); w++) begin
            ed = '0;
            ek = '0;
            el = 1'b0;
            if (w < nw) begin
                for (int k = 0; k < 8; k++) begin
                    if (idx < n) begin
                        ed[8*k +: 8] = acc_bytes[idx];
                        ek[k]        = 1'b1;
                        idx++;
                    end
                end
            end else begin
                ed = 64'(32'(n));
                ek = 8'hFF;
                el = 1'b1;
            end
            chk($sformatf("%s_w%0d_data", tag, w), cap_data[w], ed);
            chk($sformatf("%s_w%0d_keep", tag, w), 64'(cap_keep[w]), 64'(ek));
            chk($sformatf("%s_w%0d_last_done", tag, w), 64'({cap_last[w], cap_fd[w]}),
                64'({el, el}));
        end
        clear_model();
    endtask

    logic [7:0] bp_bytes[20];
    int         idx;
    int         guard;
    int         len;

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        flush           = 1'b0;
        bif.ByteIn      = '0;
        bif.ByteInValid = 1'b0;
        bif.m_tready    = 1'b1;

        // Reset state
        #1;
        chk("rst_ready", 64'(bif.ByteInReady), 64'd0);
        chk("rst_tvalid", 64'(bif.m_tvalid), 64'd0);
        chk("rst_tlast", 64'(bif.m_tlast), 64'd0);
        chk("rst_flushdone", 64'(flush_done), 64'd0);
        chk("rst_tdata", bif.m_tdata, 64'd0);
        chk("rst_tkeep", 64'(bif.m_tkeep), 64'd0);
        chk("rst_total", 64'(total_bytes), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full words 0x00..0x0F
        start_stream(1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        do_flush();
        wait_done("full");
        chk("full_word0_const", cap_data[0], 64'h0706050403020100);
        chk("full_total", 64'(total_bytes), 64'd16);
        check_stream("full");

        // Partial word; partial must be valid the cycle after flush
        start_stream(1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("part_latency_valid", 64'(bif.m_tvalid), 64'd1);
        chk("part_latency_data", bif.m_tdata, 64'h0000000000C3B2A1);
        chk("part_latency_keep", 64'(bif.m_tkeep), 64'h07);
        wait_done("part");
        check_stream("part");

        // Backpressure: 20 bytes offered with m_tready low
        for (int i = 0; i < 20; i++) bp_bytes[i] = 8'($urandom);
        bif.m_tready = 1'b0;
        start_stream(1'b0);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            bif.ByteIn      = bp_bytes[idx];
            bif.ByteInValid = 1'b1;
            @(negedge clk);
            if (bif.ByteInReady) idx++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(acc_bytes.size()), 64'd15);
        chk("bp_ready_low", 64'(bif.ByteInReady), 64'd0);
        bif.m_tready = 1'b1;
        guard        = 0;
        while (idx < 20 && guard < 100) begin
            bif.ByteIn      = bp_bytes[idx];
            bif.ByteInValid = 1'b1;
            @(negedge clk);
            if (bif.ByteInReady) idx++;
            guard++;
            @(posedge clk);
            #1;
        end
        bif.ByteInValid = 1'b0;
        chk("bp_all_sent", 64'(idx), 64'd20);
        do_flush();
        wait_done("bp");
        check_stream("bp");

        // 5th byte together with flush
        start_stream(1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        wait_done("simul");
        check_stream("simul");

        // Empty stream
        start_stream(1'b0);
        do_flush();
        wait_done("empty");
        check_stream("empty");

        // Randomized streams with random valid/ready
        for (int s = 0; s < 4; s++) begin
            len = $urandom_range(1, 40);
            start_stream(1'b0);
            idx   = 0;
            guard = 0;
            while (idx < len && guard < 2000) begin
                bif.m_tready    = ($urandom_range(0, 3) != 0);
                bif.ByteInValid = ($urandom_range(0, 3) != 0);
                bif.ByteIn      = 8'($urandom);
                @(negedge clk);
                if (bif.ByteInValid && bif.ByteInReady) idx++;
                guard++;
                @(posedge clk);
                #1;
            end
            bif.ByteInValid = 1'b0;
            bif.m_tready    = ($urandom_range(0, 1) != 0);
            do_flush();
            bif.m_tready = 1'b1;
            wait_done($sformatf("rand%0d", s));
            check_stream($sformatf("rand%0d", s));
        end

        // Async reset mid-stream
        start_stream(1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        chk("arst_pre_total", 64'(total_bytes), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(bif.m_tvalid), 64'd0);
        chk("arst_ready", 64'(bif.ByteInReady), 64'd0);
        chk("arst_total", 64'(total_bytes), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        start_stream(1'b0);
        send_byte(8'h5A, 1'b0);
        do_flush();
        wait_done("arst");
        check_stream("arst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
